// File: rtl/bus_timer_if.sv
// Single-cycle data-bus connection between the core interconnect and the timer.
interface bus_timer_if;
  logic        busSel;
  logic        busWe;
  logic [7:0]  busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;

  modport master (
    output busSel, busWe, busAddr, busWData,
    input  busRData
  );

  modport slave (
    input  busSel, busWe, busAddr, busWData,
    output busRData
  );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter, compare with optional
// auto-reload, sticky match flag driving a level interrupt.
module bus_timer #(
  parameter int unsigned PSC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  bus_timer_if.slave  bus,
  output logic        irq
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PSC    = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_CNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic                  ctrlEn;
  logic                  ctrlAr;
  logic                  ctrlIe;
  logic [PSC_WIDTH-1:0]  psc;
  logic [PSC_WIDTH-1:0]  pcnt;
  logic [DATA_WIDTH-1:0] cmp;
  logic [DATA_WIDTH-1:0] cnt;
  logic                  match;

  logic       wrAcc;
  logic [2:0] wordAddr;
  logic       ctrlWr;
  logic       pscWr;
  logic       cmpWr;
  logic       cntWr;
  logic       statusWr;
  logic       stopNow;
  logic       tick;
  logic       cntHit;
  logic       unusedAddrBits;

  // Address decode and write strobes for the current bus cycle.
  assign wrAcc          = bus.busSel & bus.busWe;
  assign wordAddr       = bus.busAddr[4:2];
  assign ctrlWr         = wrAcc && (wordAddr == OFF_CTRL);
  assign pscWr          = wrAcc && (wordAddr == OFF_PSC);
  assign cmpWr          = wrAcc && (wordAddr == OFF_CMP);
  assign cntWr          = wrAcc && (wordAddr == OFF_CNT);
  assign statusWr       = wrAcc && (wordAddr == OFF_STATUS);
  assign unusedAddrBits = ^{bus.busAddr[7:5], bus.busAddr[1:0]};

  // A disabling CTRL write cancels any tick on the same edge so CNT holds.
  assign stopNow = ctrlWr && !bus.busWData[0];
  assign tick    = ctrlEn && (pcnt == psc) && !stopNow;
  assign cntHit  = (cnt == cmp);

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlEn <= 1'b0;
      ctrlAr <= 1'b0;
      ctrlIe <= 1'b0;
      psc    <= '0;
      cmp    <= '1;
    end else begin
      if (ctrlWr) begin
        ctrlEn <= bus.busWData[0];
        ctrlAr <= bus.busWData[1];
        ctrlIe <= bus.busWData[2];
      end
      if (pscWr) psc <= bus.busWData[PSC_WIDTH-1:0];
      if (cmpWr) cmp <= bus.busWData;
    end
  end

  // Prescaler: restarts on PSC write, disable, or terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pscWr || !ctrlEn || stopNow || (pcnt == psc)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PSC_WIDTH'(1);
    end
  end

  // Main counter: bus writes take priority over the tick update.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cntWr) begin
      cnt <= bus.busWData;
    end else if (tick) begin
      cnt <= (cntHit && ctrlAr) ? '0 : cnt + DATA_WIDTH'(1);
    end
  end

  // Sticky match flag; a new match wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else if (tick && !cntWr && cntHit) begin
      match <= 1'b1;
    end else if (statusWr && bus.busWData[0]) begin
      match <= 1'b0;
    end
  end

  assign irq = match & ctrlIe;

  // Side-effect-free read mux, valid regardless of busSel.
  always_comb begin
    bus.busRData = '0;
    case (wordAddr)
      OFF_CTRL:   bus.busRData = {29'd0, ctrlIe, ctrlAr, ctrlEn};
      OFF_PSC:    bus.busRData = DATA_WIDTH'(psc);
      OFF_CMP:    bus.busRData = cmp;
      OFF_CNT:    bus.busRData = cnt;
      OFF_STATUS: bus.busRData = {31'd0, match};
      default:    bus.busRData = '0;
    endcase
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus random bus
// traffic compared against a behavioural register-level model.
`timescale 1ns/100ps
module tb_bus_timer;

  localparam int unsigned PSC_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   nChecks = 0;
  int   nFails  = 0;

  bus_timer_if bus ();

  bus_timer #(.PSC_WIDTH(PSC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  // Behavioural model state
  logic              mEn, mAr, mIe, mMatch;
  logic [PSC_W-1:0]  mPsc, mPcnt;
  logic [31:0]       mCmp, mCnt;

  task automatic modelEdge(input logic sel, input logic we, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic rst);
    logic wr, tick, setMatch;
    logic [2:0] off;
    logic [31:0] nCnt;
    logic [PSC_W-1:0] nPcnt;
    logic nMatch;
    if (rst) begin
      mEn = 0; mAr = 0; mIe = 0; mMatch = 0;
      mPsc = '0; mPcnt = '0; mCmp = 32'hFFFF_FFFF; mCnt = '0;
      return;
    end
    wr  = sel && we;
    off = addr[4:2];
    tick = mEn && (mPcnt == mPsc);
    if (wr && off == 3'd0 && !wdata[0]) tick = 0;
    if (!mEn) nPcnt = '0;
    else if (mPcnt == mPsc) nPcnt = '0;
    else nPcnt = mPcnt + 1'b1;
    if (wr && (off == 3'd1 || (off == 3'd0 && !wdata[0]))) nPcnt = '0;
    nCnt = mCnt;
    nMatch = mMatch;
    setMatch = 0;
    if (wr && off == 3'd3) nCnt = wdata;
    else if (tick) begin
      if (mCnt == mCmp) begin
        setMatch = 1;
        nCnt = mAr ? 32'd0 : mCnt + 32'd1;
      end else nCnt = mCnt + 32'd1;
    end
    if (wr && off == 3'd4 && wdata[0]) nMatch = 0;
    if (setMatch) nMatch = 1;
    if (wr && off == 3'd0) begin mEn = wdata[0]; mAr = wdata[1]; mIe = wdata[2]; end
    if (wr && off == 3'd1) mPsc = wdata[PSC_W-1:0];
    if (wr && off == 3'd2) mCmp = wdata;
    mCnt = nCnt; mPcnt = nPcnt; mMatch = nMatch;
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] off);
    case (off)
      3'd0: return {29'd0, mIe, mAr, mEn};
      3'd1: return 32'(mPsc);
      3'd2: return mCmp;
      3'd3: return mCnt;
      3'd4: return {31'd0, mMatch};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, take the edge, update the model, release the bus.
  task automatic busCycle(input logic sel, input logic we, input logic [2:0] off,
                          input logic [31:0] wdata);
    bus.busSel   = sel;
    bus.busWe    = we;
    bus.busAddr  = {3'b000, off, 2'b00};
    bus.busWData = wdata;
    @(posedge clk);
    modelEdge(sel, we, {3'b000, off, 2'b00}, wdata, reset);
    #1;
    bus.busSel = 1'b0;
    bus.busWe  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wdata);
    busCycle(1'b1, 1'b1, off, wdata);
  endtask

  task automatic idle();
    busCycle(1'b0, 1'b0, 3'd3, 32'd0);
  endtask

  task automatic readReg(input logic [2:0] off, output logic [31:0] data);
    bus.busAddr = {$urandom_range(0, 7) == 0 ? 3'b101 : 3'b000, off, 2'(($urandom_range(0, 3)))};
    #1;
    data = bus.busRData;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] expv;
    doReset();
    for (int i = 0; i < 8; i++) begin
      readReg(3'(i), d);
      expv = (i == 2) ? 32'hFFFF_FFFF : 32'd0;
      nChecks++;
      if (d !== expv) begin
        nFails++;
        $display("FAIL reset_read off=%0d got=%h exp=%h", i, d, expv);
      end
    end
    nChecks++;
    if (irq !== 1'b0) begin nFails++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] d, s;
    doReset();
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h7);
    for (int c = 1; c <= 12; c++) begin
      idle();
      readReg(3'd3, d);
      readReg(3'd4, s);
      nChecks++;
      if (d !== 32'(c % 4)) begin
        nFails++; $display("FAIL ar_cnt c=%0d got=%0d exp=%0d", c, d, c % 4);
      end
      nChecks++;
      if (s[0] !== (c >= 4) || irq !== (c >= 4)) begin
        nFails++; $display("FAIL ar_match c=%0d match=%b irq=%b exp=%b", c, s[0], irq, c >= 4);
      end
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] d, s;
    doReset();
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd1);
    wr(3'd0, 32'h3);
    for (int c = 1; c <= 18; c++) begin
      idle();
      readReg(3'd3, d);
      readReg(3'd4, s);
      nChecks++;
      if (d !== 32'((c / 3) % 2)) begin
        nFails++; $display("FAIL psc_cnt c=%0d got=%0d exp=%0d", c, d, (c / 3) % 2);
      end
      if (c == 5 || c == 6) begin
        nChecks++;
        if (s[0] !== (c == 6)) begin
          nFails++; $display("FAIL psc_match c=%0d got=%b exp=%b", c, s[0], c == 6);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d, s, expv;
    doReset();
    wr(3'd2, 32'd5);
    wr(3'd3, 32'hFFFF_FFFE);
    wr(3'd0, 32'h1);
    for (int c = 1; c <= 9; c++) begin
      idle();
      readReg(3'd3, d);
      readReg(3'd4, s);
      expv = (c == 1) ? 32'hFFFF_FFFF : 32'(c - 2);
      nChecks++;
      if (d !== expv) begin nFails++; $display("FAIL wrap_cnt c=%0d got=%h exp=%h", c, d, expv); end
      nChecks++;
      if (s[0] !== (c >= 8)) begin
        nFails++; $display("FAIL wrap_match c=%0d got=%b exp=%b", c, s[0], c >= 8);
      end
    end
  endtask

  task automatic test_collisions();
    logic [31:0] d, s;
    doReset();
    wr(3'd0, 32'h1);
    idle();
    idle();
    wr(3'd3, 32'h10);
    readReg(3'd3, d);
    nChecks++;
    if (d !== 32'h10) begin nFails++; $display("FAIL coll_cnt_write got=%h exp=10", d); end
    idle();
    readReg(3'd3, d);
    nChecks++;
    if (d !== 32'h11) begin nFails++; $display("FAIL coll_cnt_next got=%h exp=11", d); end
    doReset();
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h7);
    idle(); idle(); idle();
    wr(3'd4, 32'h1);
    readReg(3'd4, s);
    nChecks++;
    if (s[0] !== 1'b1 || irq !== 1'b1) begin
      nFails++; $display("FAIL coll_w1c_set match=%b irq=%b exp=1", s[0], irq);
    end
    wr(3'd4, 32'h1);
    readReg(3'd4, s);
    nChecks++;
    if (s[0] !== 1'b0 || irq !== 1'b0) begin
      nFails++; $display("FAIL coll_w1c_clear match=%b irq=%b exp=0", s[0], irq);
    end
  endtask

  task automatic test_disable_reset();
    logic [31:0] d;
    doReset();
    wr(3'd2, 32'd100);
    wr(3'd0, 32'h1);
    for (int c = 0; c < 7; c++) idle();
    readReg(3'd3, d);
    nChecks++;
    if (d !== 32'd7) begin nFails++; $display("FAIL dis_pre got=%0d exp=7", d); end
    wr(3'd0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      idle();
      readReg(3'd3, d);
      nChecks++;
      if (d !== 32'd7) begin nFails++; $display("FAIL dis_hold c=%0d got=%0d exp=7", c, d); end
    end
    reset = 1'b1;
    wr(3'd2, 32'd5);
    reset = 1'b0;
    readReg(3'd2, d);
    nChecks++;
    if (d !== 32'hFFFF_FFFF) begin nFails++; $display("FAIL rst_cmp got=%h exp=ffffffff", d); end
    readReg(3'd3, d);
    nChecks++;
    if (d !== 32'd0) begin nFails++; $display("FAIL rst_cnt got=%h exp=0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, w, expv;
    logic [2:0] off;
    int r;
    doReset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      off = 3'($urandom_range(0, 7));
      case (off)
        3'd0: w = 32'($urandom_range(0, 7)) | ($urandom_range(0, 3) != 0 ? 32'h1 : 32'h0);
        3'd1: w = 32'($urandom_range(0, 3));
        3'd2: w = 32'($urandom_range(0, 6));
        3'd3: w = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8));
        default: w = $urandom;
      endcase
      if (r < 20) busCycle(1'b1, 1'b1, off, w);
      else if (r < 30) busCycle(1'b0, 1'b1, off, w);
      else if (r < 35) begin
        reset = 1'b1;
        busCycle(1'b1, 1'b1, off, w);
        reset = 1'b0;
      end else idle();
      off = 3'($urandom_range(0, 7));
      readReg(off, d);
      expv = modelRead(off);
      nChecks++;
      if (d !== expv) begin
        nFails++; $display("FAIL rand_read c=%0d off=%0d got=%h exp=%h", c, off, d, expv);
      end
      nChecks++;
      if (irq !== (mMatch & mIe)) begin
        nFails++; $display("FAIL rand_irq c=%0d got=%b exp=%b", c, irq, mMatch & mIe);
      end
    end
  endtask

  initial begin
    bus.busSel   = 1'b0;
    bus.busWe    = 1'b0;
    bus.busAddr  = 8'd0;
    bus.busWData = 32'd0;
    test_reset();
    test_autoreload();
    test_prescaler();
    test_wrap();
    test_collisions();
    test_disable_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
